fpu_share_arb: RTL and testbench

//  Shares one fixed-latency, fully pipelined single-operand FPU unit (fpu_neg-style:
//  a_data/a_valid in, c_data/c_valid out) between NREQ requesters.
//  - Round-robin arbitration, at most one issue per cycle.
//  - Tags each issue with the requester id and routes each result back to its owner.
//  - Checks that the unit returns results exactly LAT cycles after issue.

---
 rtl/fpu_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fpu_share_arb.sv | 112 +++++++++++
 tb/tb_fpu_share_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FP issue scheduling slice.
package fpu_sched_pkg;

    localparam int unsigned NREQ_MAX    = 8;
    localparam int unsigned FPU_NEG_LAT = 1;

    typedef logic [$clog2(NREQ_MAX)-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (mod NREQ) wins.
module rr_arbiter
    import fpu_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] grant,
    output req_id_t         winner,
    output logic            found
);

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = req_id_t'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_share_arb.sv
// Shares one fixed-latency pipelined FPU unit between NREQ requesters,
// tagging each issue and routing results back to their owner.
module fpu_share_arb
    import fpu_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32,
    parameter int unsigned LAT  = FPU_NEG_LAT
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    input  logic            hold,
    output logic [W-1:0]    fu_a_data,
    output logic            fu_a_valid,
    input  logic [W-1:0]    fu_c_data,
    input  logic            fu_c_valid,
    output logic [NREQ-1:0] rsp_valid,
    output logic [W-1:0]    rsp_data,
    output logic            idle,
    output logic            err
);

    req_id_t         rr_ptr;
    req_id_t         win_id;
    req_id_t         fu_a_id;
    logic [NREQ-1:0] grant;
    logic            any_req;
    logic            transfer;
    logic [W-1:0]    win_data;
    tag_t            tag_pipe [LAT];
    tag_t            exp_tag;
    logic            tags_busy;
    logic            ret_ok;
    logic [NREQ-1:0] rsp_onehot;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (win_id),
        .found  (any_req)
    );

    assign transfer  = any_req & ~hold & aresetn;
    assign req_ready = transfer ? grant : '0;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) win_data = req_data[i*W +: W];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr     <= '0;
            fu_a_valid <= 1'b0;
            fu_a_data  <= '0;
            fu_a_id    <= '0;
        end else begin
            fu_a_valid <= transfer;
            if (transfer) begin
                rr_ptr    <= (32'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
                fu_a_data <= win_data;
                fu_a_id   <= win_id;
            end
        end
    end

    // The unit cannot stall, so the tag pipe shifts unconditionally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned k = 0; k < LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= tag_t'{vld: fu_a_valid, id: fu_a_id};
            for (int unsigned k = 1; k < LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign exp_tag = tag_pipe[LAT-1];
    assign ret_ok  = fu_c_valid & exp_tag.vld;

    always_comb begin
        tags_busy = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) tags_busy = tags_busy | tag_pipe[k].vld;
    end

    always_comb begin
        rsp_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_onehot[i] = (exp_tag.id == req_id_t'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= ret_ok ? rsp_onehot : '0;
            if (ret_ok) rsp_data <= fu_c_data;
            err <= err | (fu_c_valid ^ exp_tag.vld);
        end
    end

    assign idle = ~fu_a_valid & ~tags_busy & ~|rsp_valid;

endmodule

// File: tb/tb_fpu_share_arb.sv
// Bench for fpu_share_arb: two instances (2 req / LAT 1, 4 req / LAT 3) against a queue-based reference.
module tb_fpu_share_arb;

    localparam int W  = 32;
    localparam int N0 = 2;
    localparam int L0 = 1;
    localparam int N1 = 4;
    localparam int L1 = 3;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic hold    = 1'b0;

    logic [N0-1:0]   rv0 = '0;
    logic [N0*W-1:0] rd0 = '0;
    logic [N0-1:0]   rr0, rsv0;
    logic [W-1:0]    fa0_d, fc0_d, rsd0;
    logic            fa0_v, fc0_v, idle0, err0;

    logic [N1-1:0]   rv1 = '0;
    logic [N1*W-1:0] rd1 = '0;
    logic [N1-1:0]   rr1, rsv1;
    logic [W-1:0]    fa1_d, fc1_d, rsd1;
    logic            fa1_v, fc1_v, idle1, err1;

    logic inj0 = 1'b0, sup0 = 1'b0, inj1 = 1'b0, sup1 = 1'b0;

    always #5 aclk = ~aclk;

    fpu_share_arb #(.NREQ(N0), .W(W), .LAT(L0)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
        .hold(hold), .fu_a_data(fa0_d), .fu_a_valid(fa0_v), .fu_c_data(fc0_d),
        .fu_c_valid(fc0_v), .rsp_valid(rsv0), .rsp_data(rsd0), .idle(idle0), .err(err0)
    );

    fpu_share_arb #(.NREQ(N1), .W(W), .LAT(L1)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
        .hold(hold), .fu_a_data(fa1_d), .fu_a_valid(fa1_v), .fu_c_data(fc1_d),
        .fu_c_valid(fc1_v), .rsp_valid(rsv1), .rsp_data(rsd1), .idle(idle1), .err(err1)
    );

    // Negating FPU unit models with fault injection (extra valid / suppressed valid).
    logic [L0-1:0] u0v = '0;
    logic [W-1:0]  u0d [L0];
    logic [L1-1:0] u1v = '0;
    logic [W-1:0]  u1d [L1];

    always @(posedge aclk) begin
        u0v    <= (u0v << 1) | L0'(fa0_v);
        u0d[0] <= fa0_d ^ 32'h8000_0000;
        for (int k = L0 - 1; k > 0; k--) u0d[k] <= u0d[k-1];
        u1v    <= (u1v << 1) | L1'(fa1_v);
        u1d[0] <= fa1_d ^ 32'h8000_0000;
        for (int k = L1 - 1; k > 0; k--) u1d[k] <= u1d[k-1];
    end

    assign fc0_v = (u0v[L0-1] & ~sup0) | inj0;
    assign fc0_d = u0d[L0-1];
    assign fc1_v = (u1v[L1-1] & ~sup1) | inj1;
    assign fc1_d = u1d[L1-1];

    // Reference model: outstanding ops with their due response cycle.
    typedef struct {
        int          d;
        int          due;
        int          id;
        logic [31:0] data;
        bit          drop;
    } exp_t;

    exp_t        q[$];
    int          p     [2];
    bit          efav  [2];
    logic [31:0] efad  [2];
    logic [31:0] ersd  [2];
    bit          eerr  [2];
    int          cyc       = 0;
    int          checks    = 0;
    int          passed    = 0;
    int          fails     = 0;
    bit          fixed_en  = 1'b0;
    logic [31:0] fixed_val = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input logic [3:0] v, input int ptr, input int n, input bit h);
        if (h) return -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int d = 0; d < 2; d++) begin
            p[d] = 0; efav[d] = 1'b0; efad[d] = '0; ersd[d] = '0; eerr[d] = 1'b0;
        end
    endtask

    task automatic eval(input int d, input int n, input int lat, input logic [3:0] v,
                        input logic [127:0] rd, input bit h, input bit inj, input bit sup,
                        input logic [3:0] rr, input logic fav, input logic [31:0] fad,
                        input logic [3:0] rsv, input logic [31:0] rsd, input logic er,
                        input logic idl);
        int         g;
        logic [3:0] erdy;
        logic [3:0] ersv;
        bit         exists;
        bit         busy;
        g    = arb(v, p[d], n, h);
        erdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk($sformatf("d%0d.req_ready c%0d", d, cyc), rr, erdy);
        chk($sformatf("d%0d.fu_a_valid c%0d", d, cyc), fav, efav[d]);
        chk($sformatf("d%0d.fu_a_data c%0d", d, cyc), fad, efad[d]);
        exists = 1'b0;
        foreach (q[i]) begin
            if (q[i].d == d && q[i].due == cyc + 1 && !q[i].drop) begin
                exists = 1'b1;
                if (sup) q[i].drop = 1'b1;
            end
        end
        ersv = '0;
        foreach (q[i]) begin
            if (q[i].d == d && q[i].due == cyc && !q[i].drop) begin
                ersv    = 4'(1 << q[i].id);
                ersd[d] = q[i].data;
            end
        end
        chk($sformatf("d%0d.rsp_valid c%0d", d, cyc), rsv, ersv);
        chk($sformatf("d%0d.rsp_data c%0d", d, cyc), rsd, ersd[d]);
        chk($sformatf("d%0d.err c%0d", d, cyc), er, eerr[d]);
        busy = 1'b0;
        foreach (q[i]) begin
            if (q[i].d == d && cyc <= q[i].due - (q[i].drop ? 1 : 0)) busy = 1'b1;
        end
        chk($sformatf("d%0d.idle c%0d", d, cyc), idl, !busy);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].d == d && q[i].due <= cyc) q.delete(i);
        end
        if ((inj && !exists) || (sup && exists)) eerr[d] = 1'b1;
        efav[d] = (g >= 0);
        if (g >= 0) begin
            efad[d] = rd[g*32 +: 32];
            q.push_back('{d: d, due: cyc + lat + 2, id: g,
                          data: rd[g*32 +: 32] ^ 32'h8000_0000, drop: 1'b0});
            p[d] = (g + 1) % n;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic [1:0] v0, input logic [3:0] v1, input bit h,
                         input bit i0, input bit s0, input bit i1, input bit s1);
        rv0 = v0; rv1 = v1; hold = h;
        inj0 = i0; sup0 = s0; inj1 = i1; sup1 = s1;
        rd0 = {$urandom, $urandom};
        rd1 = {$urandom, $urandom, $urandom, $urandom};
        if (fixed_en) rd0[31:0] = fixed_val;
        #1;
        eval(0, N0, L0, {2'b00, rv0}, {64'b0, rd0}, h, i0, s0, {2'b00, rr0},
             fa0_v, fa0_d, {2'b00, rsv0}, rsd0, err0, idle0);
        eval(1, N1, L1, rv1, rd1, h, i1, s1, rr1, fa1_v, fa1_d, rsv1, rsd1, err1, idle1);
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic [1:0] v0, input logic [3:0] v1, input bit h);
        cycle(v0, v1, h, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".d0.req_ready"}, rr0, '0);
        chk({tag, ".d0.fu_a_valid"}, fa0_v, 1'b0);
        chk({tag, ".d0.fu_a_data"}, fa0_d, '0);
        chk({tag, ".d0.rsp_valid"}, rsv0, '0);
        chk({tag, ".d0.rsp_data"}, rsd0, '0);
        chk({tag, ".d0.err"}, err0, 1'b0);
        chk({tag, ".d0.idle"}, idle0, 1'b1);
        chk({tag, ".d1.req_ready"}, rr1, '0);
        chk({tag, ".d1.fu_a_valid"}, fa1_v, 1'b0);
        chk({tag, ".d1.fu_a_data"}, fa1_d, '0);
        chk({tag, ".d1.rsp_valid"}, rsv1, '0);
        chk({tag, ".d1.rsp_data"}, rsd1, '0);
        chk({tag, ".d1.err"}, err1, 1'b0);
        chk({tag, ".d1.idle"}, idle1, 1'b1);
    endtask

    // Asynchronous reset mid-cycle with requests pending; unit drains while held.
    task automatic do_reset();
        rv0 = '1; rv1 = '1; hold = 1'b0;
        inj0 = 1'b0; sup0 = 1'b0; inj1 = 1'b0; sup1 = 1'b0;
        #1;
        aresetn = 1'b0;
        #1;
        reset_checks("async_rst");
        model_reset();
        rv0 = '0; rv1 = '0;
        repeat (6) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc += 6;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        reset_checks("init_rst");
        aresetn = 1'b1;

        // Single op on requester 0 with a known operand.
        fixed_en  = 1'b1;
        fixed_val = 32'h3F80_0000;
        step(2'b01, 4'b0000, 1'b0);
        fixed_en  = 1'b0;
        repeat (4) step(2'b00, 4'b0000, 1'b0);

        // Bring pointers to 0 (2-req) and 2 (4-req), then contend back-to-back.
        step(2'b10, 4'b0010, 1'b0);
        repeat (4) step(2'b11, 4'b1010, 1'b0);
        repeat (6) step(2'b00, 4'b0000, 1'b0);

        // Hold blocks issue; release resumes at the current pointer.
        repeat (3) step(2'b11, 4'b1111, 1'b1);
        repeat (2) step(2'b11, 4'b1111, 1'b0);
        repeat (7) step(2'b00, 4'b0000, 1'b0);

        // Unexpected result, then a suppressed result.
        cycle(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) step(2'b00, 4'b0000, 1'b0);
        step(2'b01, 4'b0001, 1'b0);
        step(2'b00, 4'b0000, 1'b0);
        cycle(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2'b00, 4'b0000, 1'b0);
        cycle(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) step(2'b00, 4'b0000, 1'b0);

        // Reset with ops in flight, then a fresh op.
        step(2'b01, 4'b0001, 1'b0);
        step(2'b01, 4'b0001, 1'b0);
        do_reset();
        step(2'b01, 4'b0001, 1'b0);
        repeat (6) step(2'b00, 4'b0000, 1'b0);

        // Randomized traffic.
        repeat (300) begin
            step(2'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0));
        end
        repeat (8) step(2'b00, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
